// File: rtl/muldiv_ab_if.sv
`default_nettype none
// ============================================================================
// Interface : muldiv_ab_if
// Brief     : Operand, handshake and result bundle between the 8051
//             decoder/ALU (master) and the MUL AB / DIV AB unit (slave).
// Revision  : 1.0 - initial release
// ============================================================================
interface muldiv_ab_if #(
    parameter int WIDTH = 8
) ();
    // request side
    logic             start;
    logic             op;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] b_in;

    // result side
    logic             busy;
    logic             done;
    logic             wr_acc;
    logic             wr_b;
    logic [WIDTH-1:0] acc_out;
    logic [WIDTH-1:0] b_out;
    logic             ov;
    logic             cy;

    modport master (
        output start, op, acc_in, b_in,
        input  busy, done, wr_acc, wr_b, acc_out, b_out, ov, cy
    );

    modport slave (
        input  start, op, acc_in, b_in,
        output busy, done, wr_acc, wr_b, acc_out, b_out, ov, cy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ab.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ab
// Brief    : Sequential MUL AB / DIV AB execution unit for the 8051 core.
//            Shift-add multiply (LSB first) and restoring divide, one
//            iteration per clock; results land in ACC/B via one-cycle
//            write strobes together with the OV/CY flag values.
// Options  : MULDIV_FAST_MUL_EN - MUL retires two multiplier bits per
//            iteration (radix-4 partial products); DIV is unaffected.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ab #(
    parameter int WIDTH = 8
) (
    input  wire logic  clock,
    input  wire logic  reset,
    muldiv_ab_if.slave mdu
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH + 1);

`ifdef MULDIV_FAST_MUL_EN
    localparam int c_MUL_STEP = 2;
`else
    localparam int c_MUL_STEP = 1;
`endif

    localparam logic [CW-1:0] c_MUL_ITER = CW'(WIDTH / c_MUL_STEP);
    localparam logic [CW-1:0] c_DIV_ITER = CW'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------------
    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               op_q,      op_d;
    // multiplier (shifted right each MUL iteration) or divisor (static)
    logic [WIDTH-1:0]   opb_q,     opb_d;
    // multiplicand, pre-shifted to the weight of the current multiplier bit
    logic [2*WIDTH-1:0] mcand_q,   mcand_d;
    logic [2*WIDTH-1:0] prod_q,    prod_d;
    // partial remainder is always below the divisor, so WIDTH bits hold it;
    // the WIDTH+1-bit working value exists only after the shift
    logic [WIDTH-1:0]   rem_q,     rem_d;
    logic [WIDTH-1:0]   quo_q,     quo_d;
    logic [WIDTH-1:0]   acc_out_q, acc_out_d;
    logic [WIDTH-1:0]   b_out_q,   b_out_d;
    logic               ov_q,      ov_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_div_zero;
    logic [CW-1:0]      w_limit;
    logic               w_calc_last;
    logic [2*WIDTH-1:0] w_pp;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic               w_busy;
    logic               w_done;

    assign w_div_zero  = mdu.op && (mdu.b_in == '0);
    assign w_limit     = op_q ? c_DIV_ITER : c_MUL_ITER;
    // counter == limit is the extra CALC cycle that publishes the result
    assign w_calc_last = (cnt_q == w_limit);

    // Restoring divide step: shift {R,Q} left, trial-subtract the divisor,
    // keep the difference and set the quotient bit when it is non-negative.
    assign w_rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, opb_q};
    assign w_div_rem = w_diff[WIDTH+1] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_div_quo = {quo_q[WIDTH-2:0], ~w_diff[WIDTH+1]};

    // Partial product for the multiplier bit(s) currently at opb_q's LSB end
    always_comb begin
        w_pp = '0;
`ifdef MULDIV_FAST_MUL_EN
        case (opb_q[1:0])
            2'd1:    w_pp = mcand_q;
            2'd2:    w_pp = mcand_q << 1;
            2'd3:    w_pp = mcand_q + (mcand_q << 1);
            default: w_pp = '0;
        endcase
`else
        if (opb_q[0]) begin
            w_pp = mcand_q;
        end
`endif
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; divide by zero skips the iteration phase entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    state_d = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_calc_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (state_q)
            S_CALC:  w_busy = 1'b1;
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Operand capture, per-iteration MUL/DIV step and result publication
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        opb_d     = opb_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        acc_out_d = acc_out_q;
        b_out_d   = b_out_q;
        ov_d      = ov_q;

        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    op_d    = mdu.op;
                    opb_d   = mdu.b_in;
                    mcand_d = {{WIDTH{1'b0}}, mdu.acc_in};
                    prod_d  = '0;
                    rem_d   = '0;
                    quo_d   = mdu.acc_in;
                    cnt_d   = '0;
                    if (w_div_zero) begin
                        acc_out_d = mdu.acc_in;
                        b_out_d   = '0;
                        ov_d      = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (!w_calc_last) begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q) begin
                        rem_d = w_div_rem;
                        quo_d = w_div_quo;
                    end else begin
                        prod_d  = prod_q + w_pp;
                        mcand_d = mcand_q << c_MUL_STEP;
                        opb_d   = opb_q >> c_MUL_STEP;
                    end
                end else if (op_q) begin
                    acc_out_d = quo_q;
                    b_out_d   = rem_q;
                    ov_d      = 1'b0;
                end else begin
                    acc_out_d = prod_q[WIDTH-1:0];
                    b_out_d   = prod_q[2*WIDTH-1:WIDTH];
                    ov_d      = |prod_q[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            op_q      <= 1'b0;
            opb_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            acc_out_q <= '0;
            b_out_q   <= '0;
            ov_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opb_q     <= opb_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            acc_out_q <= acc_out_d;
            b_out_q   <= b_out_d;
            ov_q      <= ov_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mdu.busy    = w_busy;
    assign mdu.done    = w_done;
    assign mdu.wr_acc  = w_done;
    assign mdu.wr_b    = w_done;
    assign mdu.acc_out = acc_out_q;
    assign mdu.b_out   = b_out_q;
    assign mdu.ov      = ov_q;
    // MUL AB and DIV AB always clear carry
    assign mdu.cy      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ab.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ab
// Brief    : Self-checking bench for muldiv_ab: vector table, random ops
//            against an arithmetic model, busy-start and mid-op reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ab;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    muldiv_ab_if #(.WIDTH(8)) mdu ();

    muldiv_ab #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .mdu   (mdu.slave)
    );

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 5;
`else
    localparam int MUL_LAT = 9;
`endif
    localparam int DIV_LAT = 9;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic [7:0] exp_b;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] b;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result monitor: each done pulse retires the oldest expected result
    always @(negedge clock) begin
        if (mdu.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with nothing pending at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("acc_out", 16'(mdu.acc_out), 16'(mon_e.acc));
                chk("b_out",   16'(mdu.b_out),   16'(mon_e.b));
                chk("ov",      16'(mdu.ov),      16'(mon_e.ov));
                chk("cy",      16'(mdu.cy),      16'd0);
                chk("wr_acc",  16'(mdu.wr_acc),  16'd1);
                chk("wr_b",    16'(mdu.wr_b),    16'd1);
            end
        end
    end

    // Issue one operation, measure latency, and confirm a single done cycle
    task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ea, input logic [7:0] eb, input logic eov,
                          input int intrude_at);
        int   n;
        int   lat;
        exp_t e;
        e.acc = ea;
        e.b   = eb;
        e.ov  = eov;
        lat = (op && b == 8'h00) ? 0 : (op ? DIV_LAT : MUL_LAT);
        mdu.start  = 1'b1;
        mdu.op     = op;
        mdu.acc_in = a;
        mdu.b_in   = b;
        sb_q.push_back(e);
        @(posedge clock); #1;
        mdu.start  = 1'b0;
        mdu.op     = ~op;
        mdu.acc_in = 8'($urandom);
        mdu.b_in   = 8'($urandom);
        chk("busy_after_accept", 16'(mdu.busy), 16'd1);
        n = 0;
        while (mdu.done !== 1'b1 && n < 20) begin
            if (n == intrude_at) begin
                mdu.start  = 1'b1;
                mdu.op     = 1'b1;
                mdu.acc_in = 8'hA5;
                mdu.b_in   = 8'h00;
            end else begin
                mdu.start = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        mdu.start = 1'b0;
        chk("latency", 16'(n), 16'(lat));
        @(posedge clock); #1;
        chk("done_one_cycle",  16'(mdu.done), 16'd0);
        chk("idle_after_done", 16'(mdu.busy), 16'd0);
    endtask

    initial begin
        logic       rop;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eov;
        logic [15:0] p;

        vecs[0]  = '{1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1};
        vecs[1]  = '{1'b0, 8'h0C, 8'h0D, 8'h9C, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0};
        vecs[3]  = '{1'b1, 8'h37, 8'h00, 8'h37, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 8'h07, 8'hFF, 8'h00, 8'h07, 1'b0};
        vecs[9]  = '{1'b0, 8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1};

        mdu.start  = 1'b0;
        mdu.op     = 1'b0;
        mdu.acc_in = 8'h00;
        mdu.b_in   = 8'h00;

        // reset held for three cycles
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_busy",    16'(mdu.busy),    16'd0);
        chk("rst_done",    16'(mdu.done),    16'd0);
        chk("rst_ov",      16'(mdu.ov),      16'd0);
        chk("rst_cy",      16'(mdu.cy),      16'd0);
        chk("rst_acc_out", 16'(mdu.acc_out), 16'd0);
        chk("rst_b_out",   16'(mdu.b_out),   16'd0);

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_acc, vecs[i].exp_b, vecs[i].exp_ov, -1);
        end

        // random operations against an arithmetic model
        for (int i = 0; i < 8; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rb  = (i == 0) ? 8'h00 : 8'($urandom);
            if (rop) begin
                if (rb == 8'h00) begin
                    ea = ra; eb = 8'h00; eov = 1'b1;
                end else begin
                    ea = ra / rb; eb = ra % rb; eov = 1'b0;
                end
            end else begin
                p   = 16'(ra) * 16'(rb);
                ea  = p[7:0];
                eb  = p[15:8];
                eov = (p[15:8] != 8'h00);
            end
            run_op(rop, ra, rb, ea, eb, eov, -1);
        end

        // start pulsed while busy (at iteration 3) must be ignored
        run_op(1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 3);

        // reset during iteration 5 of a divide: no done, outputs cleared
        mdu.start  = 1'b1;
        mdu.op     = 1'b1;
        mdu.acc_in = 8'hFB;
        mdu.b_in   = 8'h12;
        @(posedge clock); #1;
        mdu.start = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy",    16'(mdu.busy),    16'd0);
        chk("abort_done",    16'(mdu.done),    16'd0);
        chk("abort_acc_out", 16'(mdu.acc_out), 16'd0);
        chk("abort_b_out",   16'(mdu.b_out),   16'd0);
        chk("abort_ov",      16'(mdu.ov),      16'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        chk("abort_still_idle", 16'(mdu.busy), 16'd0);
        run_op(1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, -1);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
